oka_partial_product_seq_8bit: RTL

OKA_PARTIAL_PRODUCT_SEQ_8BIT -- requirements
Module: oka_partial_product_seq_8bit

---
 rtl/oka_partial_product_seq_8bit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/oka_partial_product_seq_8bit.sv
// Sequential even/odd partial-product generator for a one-level odd/even
// Karatsuba-style GF(2) multiplier. Each operand is split into its even and
// odd coefficient halves; the four h x h carry-less products Ae*Be, Ae*Bo,
// Ao*Be, Ao*Bo are built by shift-and-XOR over h cycles and then held until
// the downstream overlap stage takes them.
module oka_partial_product_seq_8bit #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a_in,
  input  logic [n-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-2:0] pp1,
  output logic [n-2:0] pp2,
  output logic [n-2:0] pp3,
  output logic [n-2:0] pp4
);

  localparam int H  = n / 2;
  localparam int PW = n - 1;
  localparam int KW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [H-1:0]    r_ae, r_ao, r_be, r_bo;
  logic [PW-1:0]   r_pp1, r_pp2, r_pp3, r_pp4;

  logic [H-1:0]    w_ae_in, w_ao_in, w_be_in, w_bo_in;
  logic [PW-1:0]   w_ae_sh, w_ao_sh;
  logic            w_be_bit, w_bo_bit;
  logic            w_accept;

  // De-interleave incoming operands into even and odd coefficient halves.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_ae_in = '0;
    w_ao_in = '0;
    w_be_in = '0;
    w_bo_in = '0;
    for (int i = 0; i < H; i++) begin
      w_ae_in[i] = a_in[2*i];
      w_ao_in[i] = a_in[2*i+1];
      w_be_in[i] = b_in[2*i];
      w_bo_in[i] = b_in[2*i+1];
    end
  end

  // Current multiplier bit and shifted multiplicands for this MUL step.
  always_comb begin
    w_ae_sh  = PW'(r_ae) << r_k;
    w_ao_sh  = PW'(r_ao) << r_k;
    w_be_bit = r_be[r_k];
    w_bo_bit = r_bo[r_k];
  end

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Control FSM plus operand and accumulator registers.
  // NOTE: datapath registers are reset too, because a reset must wipe any
  // in-flight result and the captured operands, not just the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      r_state <= S_IDLE;
      r_k     <= '0;
      r_ae    <= '0;
      r_ao    <= '0;
      r_be    <= '0;
      r_bo    <= '0;
      r_pp1   <= '0;
      r_pp2   <= '0;
      r_pp3   <= '0;
      r_pp4   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ae    <= w_ae_in;
            r_ao    <= w_ao_in;
            r_be    <= w_be_in;
            r_bo    <= w_bo_in;
            r_pp1   <= '0;
            r_pp2   <= '0;
            r_pp3   <= '0;
            r_pp4   <= '0;
            r_k     <= '0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (w_be_bit) r_pp1 <= r_pp1 ^ w_ae_sh;
          if (w_bo_bit) r_pp2 <= r_pp2 ^ w_ae_sh;
          if (w_be_bit) r_pp3 <= r_pp3 ^ w_ao_sh;
          if (w_bo_bit) r_pp4 <= r_pp4 ^ w_ao_sh;
          if (r_k == KW'(H - 1)) begin
            r_k     <= '0;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign pp1       = r_pp1;
  assign pp2       = r_pp2;
  assign pp3       = r_pp3;
  assign pp4       = r_pp4;

endmodule
